masked_sbox_iter_ctrl: RTL and testbench
========================================

MASKED_SBOX_ITER_CTRL -- requirements
Module: masked_sbox_iter_ctrl

Interface
REQ-001 SHALL have parameter SEC_ORDER, default 1: masking order d; NS = d+1 shares.
REQ-002 SHALL have parameter WIDTH, default 8: bits per share.
REQ-003 SHALL have parameter LAT, default 2, minimum 1: external S-box pipeline latency in cycles.
REQ-004 SHALL have parameter MAX_ROUNDS, default 16: largest round count; RW = $clog2(MAX_ROUNDS+1).
REQ-005 SHALL have port clk, input, 1 bit: single clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: start request.
REQ-008 SHALL have port n_rounds, input, RW bits: round count, sampled when start is accepted.
REQ-009 SHALL have port value_in, input, NS*WIDTH bits: shared input; share i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port sbox_out, input, NS*WIDTH bits: shared S-box result.
REQ-011 SHALL have port sbox_in, output, NS*WIDTH bits: shared S-box operand.
REQ-012 SHALL have port value_out, output, NS*WIDTH bits: state register contents.
REQ-013 SHALL have port busy, output, 1 bit: iteration in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port synch, output, 1 bit: high in the last cycle of each round; doubles as the clock-gate enable for the state register.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL, in IDLE or DONE with start=1, accept the request, latch rounds_q = (n_rounds==0 ? 1 : min(n_rounds, MAX_ROUNDS)), clear lat_cnt and rnd_cnt, and enter RUN; start SHALL be ignored while in RUN.
REQ-018 SHALL, in RUN, increment lat_cnt every cycle, wrapping from LAT-1 to 0; synch=1 exactly when lat_cnt==LAT-1.
REQ-019 SHALL drive sbox_in from value_in for every share while rnd_cnt==0, and from value_out otherwise; selection is public, applied per share, and SHALL NOT combine shares.
REQ-020 SHALL keep value_in stable, as a user obligation, during the LAT cycles of round 0; the block does not register it.
REQ-021 SHALL load value_out <= sbox_out (all shares) only in cycles where synch=1, and hold it otherwise.
REQ-022 SHALL increment rnd_cnt in cycles where synch=1; when rnd_cnt==rounds_q-1 and synch=1, the next state SHALL be DONE.
REQ-023 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE unless start=1 (REQ-017).
REQ-024 SHALL assert busy=1 exactly while in RUN.
REQ-025 SHALL, for start accepted at edge t, assert done in cycle t + rounds_q*LAT + 1.
REQ-026 SHALL have no combinational path from start to sbox_in, busy, done or synch.

Reset
REQ-027 SHALL, when rst=0 at any time including mid-RUN, immediately set state IDLE, lat_cnt=0, rnd_cnt=0, rounds_q=1, value_out all shares 0, and busy=done=synch=0.
REQ-028 SHALL, when rst=0, leave sbox_in equal to value_in, since rnd_cnt=0.

Structure
REQ-029 SHALL place the FSM state enum and share-slice width helper in shared package masked_ctrl_pkg.
REQ-030 SHALL use one sub-module, masked_share_mux, instantiated once: an NS-share, WIDTH-bit public-select multiplexer.
REQ-031 SHALL NOT contain clock-gating cells; external gating uses synch.

Verification
REQ-032 With d=1, LAT=2, n_rounds=10, value_in={8'h5A,8'h3C}, and the S-box model an identity pipe, start at cycle 0 SHALL give done at cycle 21, value_out={8'h5A,8'h3C}, and busy high in cycles 1-20.
REQ-033 With n_rounds=0, start SHALL give done at cycle LAT+1 and exactly one synch pulse.
REQ-034 Start pulsed at cycles 3 and 7 during RUN SHALL be ignored, leaving done timing unchanged.
REQ-035 Start held high in the DONE cycle SHALL re-enter RUN with no IDLE cycle, and the second done SHALL follow at +rounds_q*LAT+1.
REQ-036 rst=0 asserted at cycle 5 of a 10-round run SHALL immediately give busy=0, value_out=0, and no done pulse; a new start afterwards SHALL complete normally.
REQ-037 With d=2 and WIDTH=4, an S-box model that XORs share i with i+1 SHALL give per-share results matching a reference model, with no cross-share mixing in sbox_in.

Source files
------------

// File: rtl/masked_ctrl_pkg.sv
// Shared types for the masked S-box iteration controller: FSM state encoding
// and the share-slice width helper used to size shared buses.
package masked_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int share_bits(input int ns, input int width);
    return ns * width;
  endfunction

endpackage

// File: rtl/masked_share_mux.sv
// NS-share public-select multiplexer, purely combinational (0 cycles).
// Each share is steered independently so no share ever meets another.
module masked_share_mux
  import masked_ctrl_pkg::*;
#(
  parameter int NS    = 2,
  parameter int WIDTH = 8
) (
  input  logic                               sel_b,
  input  logic [share_bits(NS, WIDTH)-1:0]   a,
  input  logic [share_bits(NS, WIDTH)-1:0]   b,
  output logic [share_bits(NS, WIDTH)-1:0]   y
);

  for (genvar i = 0; i < NS; i++) begin : g_share
    assign y[i*WIDTH +: WIDTH] = sel_b ? b[i*WIDTH +: WIDTH] : a[i*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/masked_sbox_iter_ctrl.sv
// Iterates a shared value through an external LAT-cycle S-box pipeline for
// rounds_q rounds; done pulses rounds_q*LAT+1 cycles after start is accepted.
module masked_sbox_iter_ctrl
  import masked_ctrl_pkg::*;
#(
  parameter int SEC_ORDER  = 1,
  parameter int WIDTH      = 8,
  parameter int LAT        = 2,
  parameter int MAX_ROUNDS = 16,
  localparam int NS = SEC_ORDER + 1,
  localparam int RW = $clog2(MAX_ROUNDS + 1),
  localparam int BW = share_bits(NS, WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] n_rounds,
  input  logic [BW-1:0] value_in,
  input  logic [BW-1:0] sbox_out,
  output logic [BW-1:0] sbox_in,
  output logic [BW-1:0] value_out,
  output logic          busy,
  output logic          done,
  output logic          synch
);

  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

  state_e        state_q, state_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [RW-1:0] rnd_cnt_q, rnd_cnt_d;
  logic [RW-1:0] rounds_q, rounds_d;
  logic [BW-1:0] value_q, value_d;
  logic          round_end;

  // Everything below depends only on flops, keeping start off these outputs.
  assign round_end = (state_q == RUN) && (lat_cnt_q == LW'(LAT - 1));
  assign synch     = round_end;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign value_out = value_q;

  masked_share_mux #(
    .NS    (NS),
    .WIDTH (WIDTH)
  ) u_share_mux (
    .sel_b (rnd_cnt_q != '0),
    .a     (value_in),
    .b     (value_q),
    .y     (sbox_in)
  );

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    rnd_cnt_d = rnd_cnt_q;
    rounds_d  = rounds_q;
    value_d   = value_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (n_rounds == '0)                    rounds_d = RW'(1);
          else if (n_rounds > RW'(MAX_ROUNDS))   rounds_d = RW'(MAX_ROUNDS);
          else                                   rounds_d = n_rounds;
          lat_cnt_d = '0;
          rnd_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        lat_cnt_d = round_end ? '0 : lat_cnt_q + LW'(1);
        if (round_end) begin
          value_d   = sbox_out;
          rnd_cnt_d = rnd_cnt_q + RW'(1);
          if (rnd_cnt_q == rounds_q - RW'(1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      rnd_cnt_q <= '0;
      rounds_q  <= RW'(1);
      value_q   <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      rnd_cnt_q <= rnd_cnt_d;
      rounds_q  <= rounds_d;
      value_q   <= value_d;
    end
  end

endmodule

// File: tb/tb_masked_sbox_iter_ctrl.sv
// Directed bench: default-parameter instance (identity S-box) plus a 3-share
// 4-bit instance whose S-box XORs share i with the constant i+1.
module tb_masked_sbox_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        start_a;
  logic [4:0]  n_rounds_a;
  logic [15:0] value_in_a, sbox_out_a, sbox_in_a, value_out_a;
  logic        busy_a, done_a, synch_a;

  logic        start_b;
  logic [4:0]  n_rounds_b;
  logic [11:0] value_in_b, sbox_out_b, sbox_in_b, value_out_b;
  logic        busy_b, done_b, synch_b;

  int total = 0;
  int bad   = 0;

  int d_first, d_last, d_num, b_num, b_first, b_last, s_num;
  logic [11:0] ref_b;

  always #5 clk = ~clk;

  masked_sbox_iter_ctrl u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .start     (start_a),
    .n_rounds  (n_rounds_a),
    .value_in  (value_in_a),
    .sbox_out  (sbox_out_a),
    .sbox_in   (sbox_in_a),
    .value_out (value_out_a),
    .busy      (busy_a),
    .done      (done_a),
    .synch     (synch_a)
  );

  masked_sbox_iter_ctrl #(
    .SEC_ORDER (2),
    .WIDTH     (4)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .n_rounds  (n_rounds_b),
    .value_in  (value_in_b),
    .sbox_out  (sbox_out_b),
    .sbox_in   (sbox_in_b),
    .value_out (value_out_b),
    .busy      (busy_b),
    .done      (done_b),
    .synch     (synch_b)
  );

  // S-box models: result is captured LAT(=2) edges after the operand is presented.
  initial begin
    sbox_out_a = '0;
    sbox_out_b = '0;
  end
  always @(posedge clk) begin
    sbox_out_a <= sbox_in_a;
    sbox_out_b <= sbox_in_b ^ 12'h321;
  end

  function automatic logic [11:0] fb(input logic [11:0] x);
    fb = {x[11:8] ^ 4'h3, x[7:4] ^ 4'h2, x[3:0] ^ 4'h1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered just after a rising edge (cycle 0); start_a is high in cycle 0 and
  // in cycles p1/p2, and the run is observed for a fixed 40-cycle window.
  task automatic measure(input int p1, input int p2);
    d_first = -1; d_last = -1; d_num = 0;
    b_num = 0; b_first = -1; b_last = -1; s_num = 0;
    for (int c = 0; c < 40; c++) begin
      start_a = (c == 0) || (c == p1) || (c == p2);
      @(negedge clk);
      if (busy_a) begin
        b_num++;
        if (b_first < 0) b_first = c;
        b_last = c;
      end
      if (done_a) begin
        d_num++;
        if (d_first < 0) d_first = c;
        d_last = c;
      end
      if (synch_a) s_num++;
      @(posedge clk); #1;
    end
    start_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start_a = 1'b0; n_rounds_a = '0; value_in_a = 16'h1234;
    start_b = 1'b0; n_rounds_b = '0; value_in_b = 12'h000;
    @(negedge clk); @(negedge clk);
    chk("rst_busy",  {31'd0, busy_a},  32'd0);
    chk("rst_done",  {31'd0, done_a},  32'd0);
    chk("rst_synch", {31'd0, synch_a}, 32'd0);
    chk("rst_vout",  {16'd0, value_out_a}, 32'd0);
    chk("rst_sbin",  {16'd0, sbox_in_a}, 32'h1234);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 10 rounds, identity S-box
    n_rounds_a = 5'd10; value_in_a = 16'h5A3C;
    measure(-1, -1);
    chk("r10_done_cyc", d_first, 21);
    chk("r10_done_num", d_num, 1);
    chk("r10_busy_num", b_num, 20);
    chk("r10_busy_first", b_first, 1);
    chk("r10_busy_last", b_last, 20);
    chk("r10_synch_num", s_num, 10);
    chk("r10_vout", {16'd0, value_out_a}, 32'h5A3C);

    // zero rounds behaves as one round
    n_rounds_a = 5'd0;
    measure(-1, -1);
    chk("r0_done_cyc", d_first, 3);
    chk("r0_synch_num", s_num, 1);
    chk("r0_busy_num", b_num, 2);

    // start pulses during RUN are ignored
    n_rounds_a = 5'd10;
    measure(3, 7);
    chk("ign_done_cyc", d_first, 21);
    chk("ign_done_num", d_num, 1);
    chk("ign_busy_num", b_num, 20);

    // round count above MAX_ROUNDS clamps to 16
    n_rounds_a = 5'd31;
    measure(-1, -1);
    chk("clamp_done_cyc", d_first, 33);
    chk("clamp_synch_num", s_num, 16);

    // start held in the DONE cycle restarts with no IDLE gap
    n_rounds_a = 5'd2;
    measure(5, -1);
    chk("b2b_done_first", d_first, 5);
    chk("b2b_done_second", d_last, 10);
    chk("b2b_done_num", d_num, 2);
    chk("b2b_busy_num", b_num, 8);
    chk("b2b_busy_last", b_last, 9);

    // asynchronous reset in cycle 5 of a 10-round run
    n_rounds_a = 5'd10; value_in_a = 16'hC3A5; start_a = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk("mid_busy_pre", {31'd0, busy_a}, 32'd1);
        chk("mid_vout_pre", {16'd0, value_out_a}, 32'hC3A5);
      end
      @(posedge clk); #1;
      start_a = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy_a}, 32'd0);
    chk("mid_vout", {16'd0, value_out_a}, 32'd0);
    chk("mid_done", {31'd0, done_a}, 32'd0);
    chk("mid_synch", {31'd0, synch_a}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    d_num = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done_a) d_num++;
    end
    chk("mid_no_done", d_num, 0);
    @(posedge clk); #1;
    n_rounds_a = 5'd4;
    measure(-1, -1);
    chk("post_rst_done_cyc", d_first, 9);
    chk("post_rst_vout", {16'd0, value_out_a}, 32'hC3A5);

    // 3 shares x 4 bits, XOR-constant S-box, 4 rounds
    n_rounds_b = 5'd4; value_in_b = 12'h96C; start_b = 1'b1;
    ref_b = 12'h96C;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) start_b = 1'b0;
      if (c == 3) value_in_b = 12'h3E1;
      @(negedge clk);
      if (c >= 1) begin
        chk($sformatf("b_sbin_c%0d", c), {20'd0, sbox_in_b}, {20'd0, (c <= 2) ? 12'h96C : ref_b});
        chk($sformatf("b_synch_c%0d", c), {31'd0, synch_b}, {31'd0, (c % 2 == 0) && (c <= 8)});
        chk($sformatf("b_busy_c%0d", c), {31'd0, busy_b}, {31'd0, c <= 8});
        chk($sformatf("b_done_c%0d", c), {31'd0, done_b}, {31'd0, c == 9});
      end
      if (c >= 3) chk($sformatf("b_vout_c%0d", c), {20'd0, value_out_b}, {20'd0, ref_b});
      if (c == 3) chk("b_vout_r1", {20'd0, value_out_b}, 32'hA4D);
      if (synch_b) ref_b = fb(ref_b);
      @(posedge clk); #1;
    end
    chk("b_vout_final", {20'd0, value_out_b}, 32'h96C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
